// File: rtl/uart_packet_parser_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_packet_parser_if
//  Purpose  : Bundles the byte-strobe input, packet valid/ready handshake and
//             error pulses of uart_packet_parser.
//  Signals  : new_data_in/data_byte_in   byte strobe from the UART receiver
//             packet_ready_in            consumer accepts the held packet
//             packet_valid_out, cmd_out, len_out, payload_out   held packet
//             *_err_out                  single-cycle error pulses
//  Modports : slave  - the parser
//             master - the environment (UART receiver + packet consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_packet_parser_if #(
  parameter int MAX_PAYLOAD = 4
) ();
  localparam int c_len_w = $clog2(MAX_PAYLOAD + 1);

  logic                     new_data_in;
  logic [7:0]               data_byte_in;
  logic                     packet_ready_in;
  logic                     packet_valid_out;
  logic [7:0]               cmd_out;
  logic [c_len_w-1:0]       len_out;
  logic [8*MAX_PAYLOAD-1:0] payload_out;
  logic                     checksum_err_out;
  logic                     len_err_out;
  logic                     overrun_err_out;
  logic                     timeout_err_out;

  modport slave (
    input  new_data_in, data_byte_in, packet_ready_in,
    output packet_valid_out, cmd_out, len_out, payload_out,
    output checksum_err_out, len_err_out, overrun_err_out, timeout_err_out
  );

  modport master (
    output new_data_in, data_byte_in, packet_ready_in,
    input  packet_valid_out, cmd_out, len_out, payload_out,
    input  checksum_err_out, len_err_out, overrun_err_out, timeout_err_out
  );
endinterface
`default_nettype wire

// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_packet_parser
//  Purpose  : Assembles UART bytes into SYNC/LEN/CMD/payload/checksum frames,
//             validates length and 8-bit additive checksum, and holds each
//             good packet on a valid/ready handshake.
//  Ports    : clk_in  - system clock
//             rst_in  - synchronous active-high reset
//             bus     - uart_packet_parser_if.slave (byte strobe, packet
//                       handshake, error pulses)
//  Options  : define UART_PARSER_TIMEOUT_EN to build the inter-byte timeout;
//             otherwise timeout_err_out is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_packet_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_PAYLOAD    = 4,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic            clk_in,
  input  wire logic            rst_in,
  uart_packet_parser_if.slave  bus
);
  localparam int         c_len_w  = $clog2(MAX_PAYLOAD + 1);
  localparam logic [7:0] c_max_pl = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  state_t                   r_state;
  logic [c_len_w-1:0]       r_len;
  logic [c_len_w-1:0]       r_idx;
  logic [7:0]               r_sum;
  logic [7:0]               r_cmd;
  logic [8*MAX_PAYLOAD-1:0] r_payload;
  logic                     r_valid;
  logic                     r_cks_err;
  logic                     r_len_err;
  logic                     r_ovr_err;

  wire logic [c_len_w-1:0]  w_idx_next = r_idx + c_len_w'(1);
  wire logic [7:0]          w_byte     = bus.data_byte_in;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [c_tmo_w-1:0] r_tmo_cnt;
  logic               r_tmo_err;
  // Counter only runs while a frame is partially received.
  wire logic w_in_frame = (r_state != ST_IDLE) && (r_state != ST_HOLD);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_cmd     <= '0;
      r_payload <= '0;
      r_valid   <= 1'b0;
      r_cks_err <= 1'b0;
      r_len_err <= 1'b0;
      r_ovr_err <= 1'b0;
`ifdef UART_PARSER_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
`endif
    end else begin
      r_cks_err <= 1'b0;
      r_len_err <= 1'b0;
      r_ovr_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.new_data_in && (w_byte == SYNC_BYTE)) r_state <= ST_LEN;
        end
        ST_LEN: begin
          if (bus.new_data_in) begin
            if (w_byte > c_max_pl) begin
              r_len_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_len     <= w_byte[c_len_w-1:0];
              r_idx     <= '0;
              r_payload <= '0;
              r_sum     <= w_byte;
              r_state   <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (bus.new_data_in) begin
            r_cmd   <= w_byte;
            r_sum   <= r_sum + w_byte;
            r_state <= (r_len == '0) ? ST_CHECK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (bus.new_data_in) begin
            // Byte lane selected by the running index; SYNC_BYTE is plain data here.
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (r_idx == c_len_w'(i)) r_payload[8*i +: 8] <= w_byte;
            end
            r_sum <= r_sum + w_byte;
            r_idx <= w_idx_next;
            if (w_idx_next == r_len) r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bus.new_data_in) begin
            if (w_byte == r_sum) begin
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end else begin
              r_cks_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          // Any byte arriving while a packet is held is lost, even on the
          // handshake cycle itself.
          if (bus.new_data_in) r_ovr_err <= 1'b1;
          if (bus.packet_ready_in) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef UART_PARSER_TIMEOUT_EN
      r_tmo_err <= 1'b0;
      if (w_in_frame) begin
        // A strobe on the limit cycle wins; the case above already consumed it.
        if (bus.new_data_in) begin
          r_tmo_cnt <= '0;
        end else if (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1)) begin
          r_tmo_cnt <= '0;
          r_tmo_err <= 1'b1;
          r_state   <= ST_IDLE;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end
`endif
    end
  end

  assign bus.packet_valid_out = r_valid;
  assign bus.cmd_out          = r_cmd;
  assign bus.len_out          = r_len;
  assign bus.payload_out      = r_payload;
  assign bus.checksum_err_out = r_cks_err;
  assign bus.len_err_out      = r_len_err;
  assign bus.overrun_err_out  = r_ovr_err;
`ifdef UART_PARSER_TIMEOUT_EN
  assign bus.timeout_err_out  = r_tmo_err;
`else
  assign bus.timeout_err_out  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle byte strobe and data byte.
- Assembles received bytes into framed command packets: SYNC, LEN, CMD, payload, checksum.
- Validates length and checksum, then holds each good packet on a valid/ready handshake for game/control logic.
- Reports framing, checksum, overrun and (optionally) timeout errors as single-cycle pulses.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- MAX_PAYLOAD, 4, maximum payload bytes per packet (>=1).
- TIMEOUT_CYCLES, 1_000_000, idle clock cycles allowed between bytes mid-frame (used only with the optional feature).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- new_data_in  input  1  one-cycle strobe; data_byte_in is valid this cycle.
- data_byte_in  input  8  received byte.
- packet_ready_in  input  1  consumer accepts the held packet.
- packet_valid_out  output  1  good packet held on the outputs.
- cmd_out  output  8  command byte of the held packet.
- len_out  output  $clog2(MAX_PAYLOAD+1)  payload byte count of the held packet.
- payload_out  output  8*MAX_PAYLOAD  payload; byte i is at [8*i +: 8]; unused bytes are 0.
- checksum_err_out  output  1  one-cycle pulse on checksum mismatch.
- len_err_out  output  1  one-cycle pulse when LEN > MAX_PAYLOAD.
- overrun_err_out  output  1  one-cycle pulse when a byte is dropped during HOLD.
- timeout_err_out  output  1  one-cycle pulse on inter-byte timeout.

Behaviour:
- Reset: rst_in sampled on posedge clk_in. All outputs go to 0, state goes to IDLE, payload register and running sum are cleared. Reset mid-frame or during HOLD discards everything.
- Bytes are processed only on cycles where new_data_in=1.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE moves to LEN. Any other byte is ignored silently, with no error.
  - LEN: if byte > MAX_PAYLOAD, pulse len_err_out and return to IDLE. Otherwise latch the length, clear the payload register, set sum = byte, and go to CMD.
  - CMD: latch cmd and add the byte to sum. Go to PAYLOAD if LEN > 0, else to CHECK.
  - PAYLOAD: store byte i at index i and add it to sum. After the LEN-th byte, go to CHECK.
  - CHECK: compare the byte against the running sum.
    - Match: go to HOLD.
    - Mismatch: pulse checksum_err_out and return to IDLE.
  - HOLD: packet_valid_out=1 with cmd_out, len_out and payload_out stable until the handshake completes.
- Sync handling: SYNC_BYTE seen mid-frame is treated as ordinary data; there is no resync.
- Checksum arithmetic: 8-bit sum modulo 256 of LEN, CMD and all payload bytes. The checksum byte must equal this sum.
- Latency (all outputs registered):
  - packet_valid_out rises on the cycle after the checksum byte's strobe.
  - Each error pulse occurs on the cycle after the offending strobe or condition.
- Handshake: packet_valid_out & packet_ready_in at a clock edge → packet_valid_out=0 next cycle and state goes to IDLE. Data outputs may keep their stale values after the handshake.
- Overrun: any new_data_in during HOLD drops the byte and pulses overrun_err_out. This includes the cycle in which the handshake completes.
- Error pulses never overlap packet_valid_out rising for the same frame.

Optional Feature:
- Macro UART_PARSER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, CMD, PAYLOAD and CHECK, and resets to 0 on every new_data_in.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe, the block pulses timeout_err_out and returns to IDLE.
  - If a strobe coincides with the limit, the byte wins and no timeout occurs.
  - The counter does not run in IDLE or HOLD.
- Not defined: no counter is built, timeout_err_out is tied to 0, and the port remains present.

Test Plan:
- Good frame: strobe A5 02 10 33 44 89 → packet_valid_out=1 one cycle after the 89 strobe, with cmd_out=10, len_out=2, payload_out=32'h0000_4433. Hold packet_ready_in=0 for 5 cycles: outputs are stable. Raise ready for 1 cycle → valid drops the next cycle.
- Bad checksum: A5 02 10 33 44 00 → a single checksum_err_out pulse and no valid. A following good frame is then accepted normally.
- Length error and zero length:
  - A5 05 → len_err_out pulse and return to IDLE.
  - Then A5 00 07 07 → valid with len_out=0, cmd_out=07, payload_out=0.
- Sync and reset: garbage 11 22 before the good frame is ignored with no error pulses. rst_in asserted after A5 02 10 → all outputs 0, and the next complete frame is accepted normally.
- Overrun: with a packet held, send 3 bytes → 3 overrun_err_out pulses, and cmd_out, len_out and payload_out are unchanged.
- Timeout (TIMEOUT_CYCLES=100):
  - With UART_PARSER_TIMEOUT_EN: A5 02 followed by 100 silent cycles → timeout_err_out pulse, and a subsequent good frame is accepted.
  - Without the macro: no pulse, and the frame completes when the bytes resume.
